// File: rtl/data_memory.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_memory : byte-addressed data RAM for the core load/store port;      |
// |   word-crossing accesses take two RAM cycles.                            |
// | Optional feature macro: DATA_MEMORY_BOUNDS_CHECK_EN                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module data_memory #(
  parameter int MEMORY_SIZE   = 4096,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     memory_request,
  input  logic [ADDRESS_WIDTH-1:0] memory_address,
  input  logic [31:0]              memory_write_data,
  input  logic [2:0]               memory_write_sections,
  output logic [31:0]              memory_read_data,
  output logic                     memory_ready,
  output logic                     memory_fault
);

  localparam int c_ADDR_BITS = $clog2(MEMORY_SIZE);
  localparam int c_WORDS     = MEMORY_SIZE / 4;
  localparam int c_IDX_BITS  = c_ADDR_BITS - 2;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SECOND = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t r_state, w_next;

  logic [31:0]           r_mem [c_WORDS];
  logic [31:0]           r_stage;
  logic [31:0]           r_rdata;
  logic [c_IDX_BITS-1:0] w_word0, w_word1, w_widx;
  logic [1:0]            w_off;
  logic [3:0]            w_en, w_be0, w_be1, w_wbe;
  logic [31:0]           w_wd0, w_wd1, w_wdat, w_lo, w_hi, w_rd, w_mask, w_merged;
  logic                  w_write, w_accept, w_cross, w_fault, w_we;
  logic                  w_unused_addr;

  assign w_off         = memory_address[1:0];
  assign w_word0       = memory_address[c_ADDR_BITS-1:2];
  assign w_word1       = w_word0 + c_IDX_BITS'(1);
  assign w_unused_addr = &{1'b0, memory_address[ADDRESS_WIDTH-1:c_ADDR_BITS]};
  assign w_write       = |memory_write_sections;
  assign w_accept      = memory_request && (r_state != S_SECOND);
  assign w_en          = w_write ? {{2{memory_write_sections[2]}}, memory_write_sections[1:0]}
                                 : 4'hF;

  // While the second half runs, the first word comes from the staging register.
  assign w_lo = (r_state == S_SECOND) ? r_stage : r_mem[w_word0];
  assign w_hi = r_mem[w_word1];

  // Scatter access bytes onto (word, lane) targets and gather read bytes back.
  always_comb begin : p_lanes
    logic [1:0] w_lane;
    logic [1:0] w_byte;
    logic       w_upper;
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
    logic [ADDRESS_WIDTH:0] w_baddr;
    w_baddr = '0;
`endif
    w_be0   = '0;
    w_be1   = '0;
    w_wd0   = '0;
    w_wd1   = '0;
    w_rd    = '0;
    w_cross = 1'b0;
    w_fault = 1'b0;
    w_lane  = '0;
    w_byte  = '0;
    w_upper = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_byte  = 2'(i);
      w_lane  = w_off + w_byte;
      w_upper = ({1'b0, w_off} + {1'b0, w_byte}) > 3'd3;
      if (w_upper) begin
        w_be1[w_lane]                    = w_en[i];
        w_wd1[{w_lane, 3'b000} +: 8]     = memory_write_data[{w_byte, 3'b000} +: 8];
        w_rd[{w_byte, 3'b000} +: 8]      = w_hi[{w_lane, 3'b000} +: 8];
        if (w_en[i]) w_cross = 1'b1;
      end else begin
        w_be0[w_lane]                    = w_en[i];
        w_wd0[{w_lane, 3'b000} +: 8]     = memory_write_data[{w_byte, 3'b000} +: 8];
        w_rd[{w_byte, 3'b000} +: 8]      = w_lo[{w_lane, 3'b000} +: 8];
      end
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
      w_baddr = {1'b0, memory_address} + (ADDRESS_WIDTH + 1)'(i);
      if (w_en[i] && (w_baddr >= (ADDRESS_WIDTH + 1)'(MEMORY_SIZE))) w_fault = 1'b1;
`endif
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_SECOND: w_next = S_DONE;
      default: begin
        if (w_accept) w_next = (w_fault || !w_cross) ? S_DONE : S_SECOND;
        else          w_next = S_IDLE;
      end
    endcase
  end

  // Write port: first word on acceptance, word+1 in the second cycle.
  assign w_we     = reset_n && w_write && !w_fault && (w_accept || (r_state == S_SECOND));
  assign w_widx   = (r_state == S_SECOND) ? w_word1 : w_word0;
  assign w_wbe    = (r_state == S_SECOND) ? w_be1 : w_be0;
  assign w_wdat   = (r_state == S_SECOND) ? w_wd1 : w_wd0;
  assign w_mask   = {{8{w_wbe[3]}}, {8{w_wbe[2]}}, {8{w_wbe[1]}}, {8{w_wbe[0]}}};
  assign w_merged = (r_mem[w_widx] & ~w_mask) | (w_wdat & w_mask);

  always_ff @(posedge clock) begin
    if (w_we) r_mem[w_widx] <= w_merged;
  end

  always_ff @(posedge clock) begin
    if (w_accept) r_stage <= r_mem[w_word0];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept && (w_fault || !w_cross))
        r_rdata <= (w_write || w_fault) ? 32'd0 : w_rd;
      else if (r_state == S_SECOND)
        r_rdata <= w_write ? 32'd0 : w_rd;
    end
  end

`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
  logic r_fault;
  always_ff @(posedge clock) begin
    if (!reset_n)      r_fault <= 1'b0;
    else if (w_accept) r_fault <= w_fault;
  end
  assign memory_fault = r_fault && (r_state == S_DONE);
`else
  assign memory_fault = 1'b0;
`endif

  assign memory_ready     = (r_state == S_DONE);
  assign memory_read_data = r_rdata;

endmodule
`default_nettype wire

// File: doc/data_memory.md
Name: data_memory

Overview:
Synthesizable byte-addressed data memory. It is the responder for the core's load/store port: it takes the core's address, write data and write-section enables, and returns read data. It replaces the behavioural memory model on the simulation side, and also serves as the FPGA data RAM. Word accesses that are not aligned and cross a word boundary are split internally into two back-to-back RAM cycles.

Parameters:
MEMORY_SIZE, 4096, size in bytes; must be a power of two and at least 8.
ADDRESS_WIDTH, 32, width of memory_address.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset_n  input  1  synchronous reset, active low.
memory_request  input  1  access valid; inputs must be held stable until memory_ready.
memory_address  input  ADDRESS_WIDTH  byte address of the access.
memory_write_data  input  32  store data; lane 0 lives at memory_address.
memory_write_sections  input  3  bit0 = byte at addr; bit1 = byte at addr+1; bit2 = bytes addr+2 and addr+3; 000 = read.
memory_read_data  output  32  bytes {addr+3, addr+2, addr+1, addr}; valid while memory_ready is high.
memory_ready  output  1  one-cycle completion pulse.
memory_fault  output  1  out-of-range access flag; valid with memory_ready.

Behaviour:
- Reset (reset_n low at an edge): state IDLE; memory_ready = 0, memory_fault = 0, memory_read_data = 0.
  - RAM contents are not cleared.
  - Reset mid-split-write leaves the first half committed; the second half is dropped.
- Storage: MEMORY_SIZE/4 words of 4 byte lanes.
  - word index = address[log2(MEMORY_SIZE)-1:2]; offset = address[1:0].
- Lane mapping: byte i of the access (i = 0..3) is enabled if:
  - write: i=0 and bit0, or i=1 and bit1, or i>=2 and bit2;
  - read: always (all four bytes).
  - Target = word (addr+i)>>2, lane (addr+i)&3.
- Crossing: an access crosses when any enabled byte targets word+1.
  - Example: sw at offset 1 crosses; sb at offset 3 does not; sh at offset 3 crosses.
- States: IDLE, SECOND, DONE.
- IDLE or DONE, memory_request = 1 at edge k:
  - First word accessed at edge k: enabled lanes written, or all four read lanes captured into a staging register.
  - Non-crossing: go to DONE; memory_ready = 1 during cycle k+1.
  - Crossing: go to SECOND.
- SECOND at edge k+1: word+1 accessed; go to DONE; memory_ready = 1 during cycle k+2. Read data is assembled from both words.
- DONE:
  - memory_ready is high for exactly one cycle.
  - A request present at the edge ending DONE is accepted as a new access, so aligned throughput is one access per cycle.
  - With no request present, go to IDLE.
- Latency: aligned/non-crossing = 1 cycle; crossing = 2 cycles. memory_request is ignored in SECOND.
- Read data in DONE:
  - Reads: memory_read_data holds assembled bytes; they remain stable until the next completion.
  - Writes: memory_read_data = 0.
- Same-address write then read: the read returns the newly written bytes (write committed at the earlier edge).
- Wrap at top of memory: see Optional Feature.
- memory_write_sections patterns other than 001/011/111 are honoured bitwise. Example: 100 writes only bytes addr+2 and addr+3.

Optional Feature:
Macro: DATA_MEMORY_BOUNDS_CHECK_EN.
- Defined:
  - Any enabled byte whose address >= MEMORY_SIZE (including word+1 beyond the last word) sets memory_fault = 1 with memory_ready.
  - The whole access is suppressed: no lanes written (the first half is not written either, because the check happens at acceptance), and memory_read_data = 0.
  - Fault accesses complete in 1 cycle.
- Undefined:
  - memory_fault is tied to 0.
  - Addresses are taken modulo MEMORY_SIZE; word+1 of the last word wraps to word 0.

Test Plan:
- Reset: hold reset_n low 2 cycles with memory_request = 1 -> memory_ready = 0, memory_fault = 0, memory_read_data = 0; then release.
- Aligned sw 0x11223344 to 0x10 at edge k -> ready at k+1; read 0x10 -> 0x11223344 at k+2 (back-to-back, 1/cycle).
- Byte/half stores:
  - sb 0xAA to 0x11 over the word above -> read 0x10 = 0x1122AA44.
  - sh 0xBEEF to 0x12 -> 0xBEEFAA44.
- Crossing sw 0xDEADBEEF to 0x0E -> ready 2 cycles after acceptance:
  - read 0x0C gives low half {EF,BE} in bytes 2..3;
  - read 0x10 gives bytes 0..1 = {AD,DE};
  - read 0x0E returns 0xDEADBEEF in 2 cycles.
- Reset asserted in SECOND of a crossing write -> state IDLE, no ready; first-word lanes updated, word+1 unchanged.
- Wrap/bounds, MEMORY_SIZE = 4096, read at 0xFFE:
  - macro defined -> memory_fault = 1, data 0, latency 1;
  - macro undefined -> bytes {word0[1:0], word 0x3FF[3:2]}, fault 0, latency 2.
